// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU port and the response port.
// The slave modport is the arbiter view; the master modport is the requester/ALU/consumer view.
interface alu_arbiter_if #(parameter int WIDTH = 64);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;
  logic             alu_z;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_z;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  alu_out, alu_cout, alu_z, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output alu_out, alu_cout, alu_z, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_STATS_EN to add per-requester accept counters grant_cnt0/grant_cnt1.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [1:0]   dbg_state_o
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [31:0]  grant_cnt0,
  output logic [31:0]  grant_cnt1
`endif
);
  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // reqN_ready may depend on reqN_valid, and rsp_valid holds with its payload until rsp_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_sel_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_cout_q;
  logic             rsp_z_q;
  logic             grant0;
  logic             grant1;
  logic             accept;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_z      = rsp_z_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= 4'b0000;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_z_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= EXEC;
            last_grant_q <= grant1;
            rsp_id_q     <= grant1;
            alu_a_q      <= grant1 ? bus.req1_a : bus.req0_a;
            alu_b_q      <= grant1 ? bus.req1_b : bus.req0_b;
            alu_sel_q    <= grant1 ? bus.req1_sel : bus.req0_sel;
          end
        end
        EXEC: begin
          // Carry-out is only meaningful for ADD; other opcodes report 0.
          state_q      <= RESP;
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= bus.alu_out;
          rsp_z_q      <= bus.alu_z;
          rsp_cout_q   <= (alu_sel_q == 4'b0010) && bus.alu_cout;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  logic [31:0] grant_cnt0_q;
  logic [31:0] grant_cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (grant0) grant_cnt0_q <= grant_cnt0_q + 32'd1;
      if (grant1) grant_cnt1_q <= grant_cnt1_q + 32'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed scenarios, then randomized traffic
// checked every cycle against a transaction-level arbitration/response model.
module tb_alu_arbiter;
  localparam int W = 64;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         cout;
    logic         z;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  logic [W:0] alu_sum;
  int         n_cmp = 0;
  int         n_err = 0;
`ifdef ALU_ARBITER_STATS_EN
  logic [31:0] grant_cnt0;
  logic [31:0] grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
`ifdef ALU_ARBITER_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  // Shared ALU: AND, OR, ADD, anything else yields zero.
  assign alu_sum      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_out  = (bus.alu_sel == 4'd0) ? (bus.alu_a & bus.alu_b) :
                        (bus.alu_sel == 4'd1) ? (bus.alu_a | bus.alu_b) :
                        (bus.alu_sel == 4'd2) ? alu_sum[W-1:0] : '0;
  assign bus.alu_cout = alu_sum[W];
  assign bus.alu_z    = (bus.alu_out == '0);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t ref_rsp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] sel);
    rsp_t       r;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b};
    r.id   = id;
    r.cout = 1'b0;
    case (sel)
      4'd0: r.res = a & b;
      4'd1: r.res = a | b;
      4'd2: begin
        r.res  = full[W-1:0];
        r.cout = full[W];
      end
      default: r.res = '0;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  rsp_t         exp_q[$];
  logic         m_busy;
  logic         m_last;
  int           m_acc_cyc;
  int           cyc = 0;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [3:0]   m_sel;
  logic [31:0]  m_cnt0;
  logic [31:0]  m_cnt1;

  always @(negedge clk) begin : mon
    logic e0, e1, ev;
    rsp_t e;
    cyc++;
    if (rst) begin
      check("ready0_in_rst", bus.req0_ready, 1'b0);
      check("ready1_in_rst", bus.req1_ready, 1'b0);
      exp_q.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      m_a    = '0;
      m_b    = '0;
      m_sel  = 4'd0;
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      e0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
      e1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
      check("req0_ready", bus.req0_ready, e0);
      check("req1_ready", bus.req1_ready, e1);
      check("alu_a", bus.alu_a, m_a);
      check("alu_b", bus.alu_b, m_b);
      check("alu_sel", bus.alu_sel, m_sel);
`ifdef ALU_ARBITER_STATS_EN
      check("grant_cnt0", grant_cnt0, m_cnt0);
      check("grant_cnt1", grant_cnt1, m_cnt1);
`endif
      ev = m_busy && (cyc >= m_acc_cyc + 2);
      check("rsp_valid", bus.rsp_valid, ev);
      if (ev && exp_q.size() > 0) begin
        e = exp_q[0];
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_result", bus.rsp_result, e.res);
        check("rsp_cout", bus.rsp_cout, e.cout);
        check("rsp_z", bus.rsp_z, e.z);
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end
      if (e0 || e1) begin
        m_last    = e1;
        m_busy    = 1'b1;
        m_acc_cyc = cyc;
        m_a       = e1 ? bus.req1_a : bus.req0_a;
        m_b       = e1 ? bus.req1_b : bus.req0_b;
        m_sel     = e1 ? bus.req1_sel : bus.req0_sel;
        exp_q.push_back(ref_rsp(e1, m_a, m_b, m_sel));
        if (e1) m_cnt1 = m_cnt1 + 32'd1;
        else    m_cnt0 = m_cnt0 + 32'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sel);
    if (r == 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = a;
      bus.req0_b     = b;
      bus.req0_sel   = sel;
    end else begin
      bus.req1_valid = 1'b1;
      bus.req1_a     = a;
      bus.req1_b     = b;
      bus.req1_sel   = sel;
    end
  endtask

  // Returns one cycle after the accept cycle (i.e. inside EXEC), valid dropped.
  task automatic wait_accept(input int r);
    int  n;
    bit  hit;
    n   = 0;
    hit = 0;
    while (!hit && n < 50) begin
      @(negedge clk);
      hit = (r == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
      n++;
    end
    if (!hit) check("accept_timeout", 1'b1, 1'b0);
    tick();
    if (r == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic id, input logic [W-1:0] res, input logic c, input logic z);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 10);
    check("rsp_latency", W'(n), W'(2));
    check("d_rsp_id", bus.rsp_id, id);
    check("d_rsp_result", bus.rsp_result, res);
    check("d_rsp_cout", bus.rsp_cout, c);
    check("d_rsp_z", bus.rsp_z, z);
    tick();
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      2:       return W'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    int          ids[$];
    int          cyc_of[$];
    logic [W-1:0] held;
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_sel   = 4'd0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_sel   = 4'd0;
    bus.rsp_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_alu_a", bus.alu_a, '0);
    check("rst_alu_sel", bus.alu_sel, 4'd0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, 1'b0);
    check("rst_rsp_result", bus.rsp_result, '0);
    check("rst_rsp_cout", bus.rsp_cout, 1'b0);
    check("rst_rsp_z", bus.rsp_z, 1'b0);
    tick();

    // Basic ADD, all-ones ADD carry, unsupported opcode, OR with carry gated off.
    set_req(0, 64'h5, 64'h3, 4'b0010);
    wait_accept(0);
    expect_rsp(1'b0, 64'h8, 1'b0, 1'b0);
    set_req(1, '1, 64'h1, 4'b0010);
    wait_accept(1);
    expect_rsp(1'b1, '0, 1'b1, 1'b1);
    set_req(0, 64'hFF, 64'hFF, 4'b1111);
    wait_accept(0);
    expect_rsp(1'b0, '0, 1'b0, 1'b1);
    set_req(1, '1, 64'h1, 4'b0001);
    wait_accept(1);
    expect_rsp(1'b1, '1, 1'b0, 1'b0);

    // Both requesters continuously valid: grants alternate, one accept per 3 cycles.
    set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0000);
    set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0001);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.req0_valid && bus.req0_ready) begin ids.push_back(0); cyc_of.push_back(k); end
      if (bus.req1_valid && bus.req1_ready) begin ids.push_back(1); cyc_of.push_back(k); end
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_accept_count", W'(ids.size()), W'(4));
    for (int k = 0; k < ids.size(); k++) begin
      check("rr_grant_id", W'(ids[k]), W'(k % 2));
      if (k > 0) check("rr_interval", W'(cyc_of[k] - cyc_of[k-1]), W'(3));
    end
    repeat (4) tick();

    // Back-pressure: response held for 5 cycles while req0 waits.
    bus.rsp_ready = 1'b0;
    set_req(1, 64'h1234, 64'h00FF, 4'b0000);
    wait_accept(1);
    set_req(0, 64'h10, 64'h20, 4'b0010);
    tick();
    held = bus.rsp_result;
    repeat (5) begin
      @(negedge clk);
      check("stall_result", bus.rsp_result, held);
      check("stall_ready0", bus.req0_ready, 1'b0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_handshake", bus.rsp_valid, 1'b1);
    @(negedge clk);
    check("resume_accept", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    repeat (4) tick();

    // Reset during EXEC discards the op; next tie goes to requester 0.
    set_req(0, 64'hF0F0, 64'h0FF0, 4'b0000);
    wait_accept(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 64'h1, 64'h2, 4'b0001);
    set_req(1, 64'h3, 64'h4, 4'b0001);
    @(negedge clk);
    check("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("post_rst_tie_r0", bus.req0_ready, 1'b1);
    check("post_rst_tie_r1", bus.req1_ready, 1'b0);
`ifdef ALU_ARBITER_STATS_EN
    check("post_rst_cnt0", grant_cnt0, '0);
    check("post_rst_cnt1", grant_cnt1, '0);
`endif
    tick();
    bus.req0_valid = 1'b0;
    wait_accept(1);
    repeat (4) tick();

    // Randomized traffic with back-pressure and occasional resets.
    for (int k = 0; k < 600; k++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_a     = rnd_op();
      bus.req0_b     = rnd_op();
      bus.req0_sel   = 4'($urandom_range(0, 5));
      bus.req1_a     = rnd_op();
      bus.req1_b     = rnd_op();
      bus.req1_sel   = 4'($urandom_range(0, 5));
      bus.rsp_ready  = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst            = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (6) tick();
    check("drain_queue_empty", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the operand/result width shared with the ALU datapath.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 req0_valid/req1_valid  input  1 each  SHALL flag a pending operation from requester 0/1.
REQ-005 req0_ready/req1_ready  output  1 each  SHALL flag acceptance of the requester's operation this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  SHALL carry the operands.
REQ-007 req0_sel/req1_sel  input  4 each  SHALL carry the ALU opcode (0000 AND, 0001 OR, 0010 ADD, other -> zero result).
REQ-008 alu_a, alu_b  output  WIDTH  SHALL drive the shared ALU operands from internal registers.
REQ-009 alu_sel  output  4  SHALL drive the shared ALU opcode from an internal register.
REQ-010 alu_out  input  WIDTH; alu_cout  input  1; alu_z  input  1  SHALL return the ALU result, adder carry-out and zero flag.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  SHALL form the single response handshake.
REQ-012 rsp_id  output  1  SHALL identify the requester owning the response.
REQ-013 rsp_result  output  WIDTH; rsp_cout  output  1; rsp_z  output  1  SHALL carry the registered result and flags.

Function
REQ-014 FSM states IDLE, EXEC, RESP SHALL be the only states; IDLE->EXEC on accept, EXEC->RESP unconditionally after one cycle, RESP->IDLE on rsp_valid&rsp_ready.
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-016 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last wins; last_grant updates only on accept.
REQ-017 On accept (cycle N) the winner's a, b, sel SHALL be registered onto alu_a/alu_b/alu_sel, stable from N+1 until next accept.
REQ-018 In EXEC (cycle N+1) alu_out, alu_z and alu_cout SHALL be captured into rsp_result, rsp_z, rsp_cout; rsp_valid SHALL rise in N+2.
REQ-019 rsp_cout SHALL equal alu_cout when captured sel is 0010, else 0.
REQ-020 rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-021 No new request SHALL be accepted before the response handshake completes; minimum issue interval is 3 cycles.
REQ-022 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-023 Unsupported sel values SHALL pass through; response carries result 0, z=1, cout=0.

Reset
REQ-024 rst=1 SHALL force state IDLE, last_grant=1 (requester 0 wins the first tie), alu_a=alu_b=0, alu_sel=0000, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_z=0, req0_ready=req1_ready=0.
REQ-025 rst during EXEC or RESP SHALL discard the in-flight operation; no response for it is ever produced.
REQ-026 reqN_ready SHALL be 0 in the cycle rst is high; accept possible from the first cycle after rst falls.

Configuration
REQ-027 Macro ALU_ARBITER_STATS_EN defined SHALL add outputs grant_cnt0, grant_cnt1 (32 bits each) counting accepts per requester, reset to 0, wrapping 0xFFFFFFFF->0.
REQ-028 Without ALU_ARBITER_STATS_EN the counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-029 req0 a=0x5, b=0x3, sel=0010, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, result=0x8, cout=0, z=0.
REQ-030 req1 a=0xFFFFFFFFFFFFFFFF, b=0x1, sel=0010 -> result=0, cout=1, z=1, rsp_id=1.
REQ-031 Both valid continuously, sel=0000/0001, rsp_ready=1 -> grants alternate 0,1,0,1; each response id matches, one accept per 3 cycles.
REQ-032 rsp_ready=0 for 5 cycles after rsp_valid -> response fields stable, both ready low; accept resumes the cycle after handshake.
REQ-033 rst pulsed in EXEC of req0 AND -> no rsp_valid afterwards; next tie grants requester 0; with ALU_ARBITER_STATS_EN counters read 0.
REQ-034 req0 sel=1111, a=b=0xFF -> result=0, z=1, cout=0.
